// File: rtl/ocx_tl_vc1_tx_ctl.sv
// ocx_tl_vc1_tx_ctl: host-side VC1 command queue with credit-gated issue to the flit framer.
// Command payloads live in an external RAM; only each entry's data-flit count is shadowed here.

module ocx_tl_vc1_credit_ctr #(
    parameter int CREDIT_WIDTH = 7,
    parameter int RET_WIDTH    = 6
) (
    input  logic                    tlx_clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    load,
    input  logic [5:0]              load_val,
    input  logic                    ret_valid,
    input  logic [RET_WIDTH-1:0]    ret_amt,
    input  logic [2:0]              consume,
    output logic [CREDIT_WIDTH-1:0] cnt,
    output logic                    sat
);
    localparam int SW = CREDIT_WIDTH + 1;

    logic [SW-1:0] sum;

    // Consumption never exceeds the pre-update count, so only overflow is possible.
    always_comb begin
        sum = {1'b0, cnt};
        if (ret_valid) sum = sum + SW'(ret_amt);
        sum = sum - SW'(consume);
    end

    assign sat = ~flush & ~load & sum[CREDIT_WIDTH];

    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n)              cnt <= '0;
        else if (flush)            cnt <= '0;
        else if (load)             cnt <= CREDIT_WIDTH'(load_val);
        else if (sum[CREDIT_WIDTH]) cnt <= '1;
        else                       cnt <= sum[CREDIT_WIDTH-1:0];
    end
endmodule

module ocx_tl_vc1_tx_ctl #(
    parameter int addr_width   = 6,
    parameter int DATA_WIDTH   = 56,
    parameter int CREDIT_WIDTH = 7
) (
    input  logic                    tlx_clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    input  logic [DATA_WIDTH-1:0]   cmd_info,
    input  logic [1:0]              cmd_dflit_cnt,
    output logic                    cmd_ready,
    output logic                    wr_ena,
    output logic [addr_width-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    rd_ena,
    output logic [addr_width-1:0]   rd_addr,
    input  logic                    tx_ready,
    output logic                    tx_cmd_valid,
    output logic [1:0]              tx_dflit_cnt,
    input  logic                    credit_init_load,
    input  logic [5:0]              tlx_vc1_initial_credit,
    input  logic [5:0]              tlx_dcp1_initial_credit,
    input  logic                    credit_return_valid,
    input  logic [3:0]              credit_return_vc1,
    input  logic [5:0]              credit_return_dcp1,
    input  logic                    tx_flush,
    output logic [CREDIT_WIDTH-1:0] vc1_credit_cnt,
    output logic [CREDIT_WIDTH-1:0] dcp1_credit_cnt,
    output logic                    fifo_empty,
    output logic                    credit_overflow_err
);
    localparam int DEPTH = 1 << addr_width;

    logic [addr_width:0] wr_ptr;
    logic [addr_width:0] rd_ptr;
    logic [1:0]          dflit_shadow [DEPTH];
    logic                full;
    logic                credit_init_done;
    logic [1:0]          head_code;
    logic [2:0]          head_flits;
    logic [2:0]          dcp1_consume;
    logic                vc1_sat;
    logic                dcp1_sat;

    assign full       = (wr_ptr[addr_width-1:0] == rd_ptr[addr_width-1:0]) &
                        (wr_ptr[addr_width] != rd_ptr[addr_width]);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign cmd_ready  = ~full;

    // A push that coincides with a flush is dropped along with the queue contents.
    assign wr_ena  = cmd_valid & cmd_ready & ~tx_flush;
    assign wr_addr = wr_ptr[addr_width-1:0];
    assign wr_data = cmd_info;
    assign rd_addr = rd_ptr[addr_width-1:0];

    assign head_code  = dflit_shadow[rd_addr];
    assign head_flits = (head_code == 2'b11) ? 3'd4 : {1'b0, head_code};

    assign rd_ena = ~fifo_empty & credit_init_done & tx_ready &
                    (vc1_credit_cnt != '0) &
                    (dcp1_credit_cnt >= CREDIT_WIDTH'(head_flits)) & ~tx_flush;

    assign dcp1_consume = rd_ena ? head_flits : 3'd0;

    always_ff @(posedge tlx_clk) begin
        if (wr_ena) dflit_shadow[wr_addr] <= cmd_dflit_cnt;
    end

    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (tx_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ena) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ena) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n)              credit_init_done <= 1'b0;
        else if (tx_flush)         credit_init_done <= 1'b0;
        else if (credit_init_load) credit_init_done <= 1'b1;
    end

    // Matches the one-cycle RAM read latency; a read launched before a flush still completes.
    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_cmd_valid <= 1'b0;
            tx_dflit_cnt <= 2'b00;
        end else begin
            tx_cmd_valid <= rd_ena;
            tx_dflit_cnt <= rd_ena ? head_code : 2'b00;
        end
    end

    ocx_tl_vc1_credit_ctr #(
        .CREDIT_WIDTH (CREDIT_WIDTH),
        .RET_WIDTH    (4)
    ) u_vc1_ctr (
        .tlx_clk   (tlx_clk),
        .reset_n   (reset_n),
        .flush     (tx_flush),
        .load      (credit_init_load),
        .load_val  (tlx_vc1_initial_credit),
        .ret_valid (credit_return_valid),
        .ret_amt   (credit_return_vc1),
        .consume   ({2'b00, rd_ena}),
        .cnt       (vc1_credit_cnt),
        .sat       (vc1_sat)
    );

    ocx_tl_vc1_credit_ctr #(
        .CREDIT_WIDTH (CREDIT_WIDTH),
        .RET_WIDTH    (6)
    ) u_dcp1_ctr (
        .tlx_clk   (tlx_clk),
        .reset_n   (reset_n),
        .flush     (tx_flush),
        .load      (credit_init_load),
        .load_val  (tlx_dcp1_initial_credit),
        .ret_valid (credit_return_valid),
        .ret_amt   (credit_return_dcp1),
        .consume   (dcp1_consume),
        .cnt       (dcp1_credit_cnt),
        .sat       (dcp1_sat)
    );

    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n)                credit_overflow_err <= 1'b0;
        else if (vc1_sat | dcp1_sat) credit_overflow_err <= 1'b1;
    end
endmodule
